// File: rtl/apple_pkg.sv
// Shared types and constants for the apple field: screen defaults, state enum,
// LFSR feedback mask, start-of-game position table and respawn range folding.
package apple_pkg;

    localparam int APPLE_SIZE_DEF = 14;
    localparam int SCR_W_DEF      = 640;
    localparam int SCR_H_DEF      = 480;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        ACTIVE,
        EATEN,
        RESPAWN
    } apple_state_t;

    function automatic logic [9:0] default_x(input int idx, input int span);
        case (idx)
            0:       return 10'd35;
            1:       return 10'd135;
            2:       return 10'd205;
            3:       return 10'd440;
            4:       return 10'd600;
            default: return 10'((idx * 97) % span);
        endcase
    endfunction

    function automatic logic [9:0] default_y(input int idx, input int span);
        case (idx)
            0:       return 10'd80;
            1:       return 10'd300;
            2:       return 10'd400;
            3:       return 10'd290;
            4:       return 10'd50;
            default: return 10'((idx * 61) % span);
        endcase
    endfunction

    // Wraps a raw 10-bit random coordinate into [0, span); below 2*span this is a single subtract
    function automatic logic [9:0] fold_pos(input logic [9:0] v, input int span);
        int t;
        t = int'(v);
        return 10'(t % span);
    endfunction

endpackage

// File: rtl/apple_lfsr.sv
// Seedable 16-bit Galois LFSR supplying respawn coordinates; a zero seed is replaced by 1.
module apple_lfsr
    import apple_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= SEED_NZ;
        end else if (en) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/apple_field.sv
// Apple field: per-pixel apple coverage, head collision per game tick, score keeping
// and delayed pseudo-random respawn of eaten apples.
module apple_field
    import apple_pkg::*;
#(
    parameter int          NUM_APPLES    = 5,
    parameter int          APPLE_SIZE    = APPLE_SIZE_DEF,
    parameter int          SCR_W         = SCR_W_DEF,
    parameter int          SCR_H         = SCR_H_DEF,
    parameter int          RESPAWN_TICKS = 8,
    parameter int          SCORE_W       = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update,
    input  logic [9:0]            xLength,
    input  logic [9:0]            yLength,
    input  logic [9:0]            head_x,
    input  logic [9:0]            head_y,
    output logic [NUM_APPLES-1:0] apple,
    output logic                  eaten,
    output logic [NUM_APPLES-1:0] eaten_mask,
    output logic [SCORE_W-1:0]    score,
    output logic                  all_eaten
);

    localparam int X_SPAN = SCR_W - APPLE_SIZE;
    localparam int Y_SPAN = SCR_H - APPLE_SIZE;
    localparam int CNT_W  = $clog2(NUM_APPLES + 1);
    localparam int SUM_W  = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
    localparam logic [SCORE_W-1:0]    SCORE_MAX = '1;
    localparam logic [NUM_APPLES-1:0] ONE_VEC   = NUM_APPLES'(1);

    function automatic logic inside_box(input logic [9:0] px, input logic [9:0] py,
                                        input logic [9:0] ax, input logic [9:0] ay);
        logic [10:0] x0, y0, x1, y1;
        x0 = {1'b0, ax};
        y0 = {1'b0, ay};
        x1 = x0 + 11'(APPLE_SIZE);
        y1 = y0 + 11'(APPLE_SIZE);
        return ({1'b0, px} >= x0) && ({1'b0, px} < x1) &&
               ({1'b0, py} >= y0) && ({1'b0, py} < y1);
    endfunction

    logic                  update_q;
    logic                  tick;
    logic [15:0]           lfsr;
    logic [9:0]            spawn_x;
    logic [9:0]            spawn_y;
    logic [NUM_APPLES-1:0] hit;
    logic [NUM_APPLES-1:0] req;
    logic [NUM_APPLES-1:0] grant;
    logic [NUM_APPLES-1:0] cov;
    logic [NUM_APPLES-1:0] active_next;
    logic [CNT_W-1:0]      hit_cnt;
    logic [SUM_W-1:0]      score_sum;
    logic [SCORE_W-1:0]    score_n;

    assign tick    = update & ~update_q;
    assign spawn_x = fold_pos(lfsr[9:0], X_SPAN);
    assign spawn_y = fold_pos(lfsr[15:6], Y_SPAN);

    // Lowest requesting index wins; at most one apple respawns per tick
    assign grant = req & (~req + ONE_VEC);

    apple_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .lfsr (lfsr)
    );

    for (genvar g = 0; g < NUM_APPLES; g++) begin : g_apple
        apple_state_t state;
        apple_state_t state_n;
        logic [7:0]   timer;
        logic [7:0]   timer_n;
        logic [9:0]   ax;
        logic [9:0]   ay;
        logic [9:0]   ax_n;
        logic [9:0]   ay_n;

        // An apple whose delay expires this tick may be granted at once, skipping the pending state
        assign hit[g]         = tick && (state == ACTIVE) && inside_box(head_x, head_y, ax, ay);
        assign req[g]         = tick && ((state == RESPAWN) || ((state == EATEN) && (timer == 8'd0)));
        assign cov[g]         = (state == ACTIVE) && inside_box(xLength, yLength, ax, ay);
        assign active_next[g] = (state_n == ACTIVE);

        always_comb begin
            state_n = state;
            timer_n = timer;
            ax_n    = ax;
            ay_n    = ay;
            if (tick) begin
                case (state)
                    ACTIVE: begin
                        if (hit[g]) begin
                            state_n = EATEN;
                            timer_n = 8'(RESPAWN_TICKS);
                        end
                    end
                    EATEN: begin
                        if (timer != 8'd0) begin
                            timer_n = timer - 8'd1;
                        end else if (grant[g]) begin
                            state_n = ACTIVE;
                            ax_n    = spawn_x;
                            ay_n    = spawn_y;
                        end else begin
                            state_n = RESPAWN;
                        end
                    end
                    RESPAWN: begin
                        if (grant[g]) begin
                            state_n = ACTIVE;
                            ax_n    = spawn_x;
                            ay_n    = spawn_y;
                        end
                    end
                    default: state_n = ACTIVE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state <= ACTIVE;
                timer <= 8'd0;
                ax    <= default_x(g, X_SPAN);
                ay    <= default_y(g, Y_SPAN);
            end else begin
                state <= state_n;
                timer <= timer_n;
                ax    <= ax_n;
                ay    <= ay_n;
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_APPLES; i++) begin
            hit_cnt = hit_cnt + CNT_W'(hit[i]);
        end
        score_sum = SUM_W'(score) + SUM_W'(hit_cnt);
        score_n   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            update_q   <= 1'b0;
            apple      <= '0;
            eaten      <= 1'b0;
            eaten_mask <= '0;
            score      <= '0;
            all_eaten  <= 1'b0;
        end else begin
            update_q   <= update;
            apple      <= cov;
            eaten      <= |hit;
            eaten_mask <= hit;
            score      <= score_n;
            all_eaten  <= ~|active_next;
        end
    end

endmodule

// File: tb/tb_apple_field.sv
// Directed bench for apple_field: pixel coverage, eating, respawn timing/position,
// tick edge detection, saturation, all-eaten and reset recovery.
module tb_apple_field;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       update = 1'b0;
    logic       update2 = 1'b0;
    logic [9:0] xLength = '0;
    logic [9:0] yLength = '0;
    logic [9:0] head_x = '0;
    logic [9:0] head_y = '0;
    logic [9:0] head2_x = '0;
    logic [9:0] head2_y = '0;
    logic [4:0] apple, apple2, eaten_mask, eaten_mask2;
    logic       eaten, eaten2, all_eaten, all_eaten2;
    logic [7:0] score;
    logic [1:0] score2;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] lfsrModel;
    logic [15:0] lfsrAtTick;
    int          ex, ey, pulses, expScore;

    always #5 clk = ~clk;

    // Reference LFSR, stepped alongside the design from the same reset
    always @(posedge clk) begin
        if (!rst) lfsrModel <= 16'hACE1;
        else      lfsrModel <= {1'b0, lfsrModel[15:1]} ^ (lfsrModel[0] ? 16'hB400 : 16'h0000);
    end

    apple_field u_dut (
        .clk        (clk),
        .rst        (rst),
        .update     (update),
        .xLength    (xLength),
        .yLength    (yLength),
        .head_x     (head_x),
        .head_y     (head_y),
        .apple      (apple),
        .eaten      (eaten),
        .eaten_mask (eaten_mask),
        .score      (score),
        .all_eaten  (all_eaten)
    );

    apple_field #(
        .APPLE_SIZE    (240),
        .SCORE_W       (2),
        .RESPAWN_TICKS (255)
    ) u_big (
        .clk        (clk),
        .rst        (rst),
        .update     (update2),
        .xLength    (xLength),
        .yLength    (yLength),
        .head_x     (head2_x),
        .head_y     (head2_y),
        .apple      (apple2),
        .eaten      (eaten2),
        .eaten_mask (eaten_mask2),
        .score      (score2),
        .all_eaten  (all_eaten2)
    );

    function automatic bit insideTb(int px, int py, int ax, int ay, int sz);
        return (px >= ax) && (px < ax + sz) && (py >= ay) && (py < ay + sz);
    endfunction

    function automatic int foldTb(int v, int span);
        int t;
        t = v;
        while (t >= span) t = t - span;
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int sx, input int sy);
        xLength = 10'(sx);
        yLength = 10'(sy);
        @(negedge clk);
    endtask

    task automatic doTick();
        update     = 1'b1;
        lfsrAtTick = lfsrModel;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic doTick2();
        update2 = 1'b1;
        @(negedge clk);
        update2 = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_apple", 16'(apple), 16'h0);
        checkOutput("rst_eaten", 16'(eaten), 16'h0);
        checkOutput("rst_mask", 16'(eaten_mask), 16'h0);
        checkOutput("rst_score", 16'(score), 16'h0);
        checkOutput("rst_all_eaten", 16'(all_eaten), 16'h0);
        rst = 1'b1;

        applyStimulus(35, 80);  checkOutput("pix_35_80", 16'(apple[0]), 16'h1);
        applyStimulus(48, 93);  checkOutput("pix_48_93", 16'(apple[0]), 16'h1);
        applyStimulus(49, 93);  checkOutput("pix_49_93", 16'(apple[0]), 16'h0);
        applyStimulus(34, 80);  checkOutput("pix_34_80", 16'(apple[0]), 16'h0);
        checkOutput("score_idle", 16'(score), 16'h0);

        head_x = 10'd140; head_y = 10'd305;
        doTick();
        checkOutput("eat1_eaten", 16'(eaten), 16'h1);
        checkOutput("eat1_mask", 16'(eaten_mask), 16'h02);
        checkOutput("eat1_score", 16'(score), 16'h1);
        checkOutput("eat1_all", 16'(all_eaten), 16'h0);
        @(negedge clk);
        checkOutput("eat1_pulse_end", 16'(eaten), 16'h0);
        checkOutput("eat1_mask_end", 16'(eaten_mask), 16'h0);
        applyStimulus(135, 300); checkOutput("eat1_gone", 16'(apple[1]), 16'h0);

        head_x = 10'd0; head_y = 10'd0;
        for (int k = 0; k < 8; k++) begin
            doTick();
            @(negedge clk);
        end
        applyStimulus(135, 300); checkOutput("wait8_gone", 16'(apple[1]), 16'h0);
        checkOutput("wait8_score", 16'(score), 16'h1);

        doTick();
        @(negedge clk);
        ex = foldTb(int'(lfsrAtTick[9:0]), 626);
        ey = foldTb(int'(lfsrAtTick[15:6]), 466);
        applyStimulus(ex, ey);           checkOutput("rsp_corner", 16'(apple[1]), 16'h1);
        applyStimulus(ex + 13, ey + 13); checkOutput("rsp_far", 16'(apple[1]), 16'h1);
        applyStimulus(ex + 14, ey);      checkOutput("rsp_right_out", 16'(apple[1]), 16'h0);
        if (ex > 0) begin
            applyStimulus(ex - 1, ey);   checkOutput("rsp_left_out", 16'(apple[1]), 16'h0);
        end

        head_x = 10'd605; head_y = 10'd55;
        expScore = 2 + (insideTb(605, 55, ex, ey, 14) ? 1 : 0);
        update = 1'b1;
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (eaten) pulses++;
        end
        update = 1'b0;
        @(negedge clk);
        checkOutput("held_pulses", 16'(pulses), 16'h1);
        checkOutput("held_score", 16'(score), 16'(expScore));

        head_x = 10'(ex); head_y = 10'(ey);
        doTick(); @(negedge clk);
        head_x = 10'd40; head_y = 10'd85;
        doTick(); @(negedge clk);
        head_x = 10'd210; head_y = 10'd405;
        doTick(); @(negedge clk);
        checkOutput("pre_all", 16'(all_eaten), 16'(insideTb(ex, ey, 440, 290, 14)));
        head_x = 10'd445; head_y = 10'd295;
        doTick(); @(negedge clk);
        checkOutput("all_score", 16'(score), 16'h6);
        checkOutput("all_eaten", 16'(all_eaten), 16'h1);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_score", 16'(score), 16'h0);
        checkOutput("mid_rst_all", 16'(all_eaten), 16'h0);
        checkOutput("mid_rst_apple", 16'(apple), 16'h0);
        rst = 1'b1;
        applyStimulus(135, 300); checkOutput("post_rst_a1", 16'(apple[1]), 16'h1);
        applyStimulus(600, 50);  checkOutput("post_rst_a4", 16'(apple[4]), 16'h1);
        applyStimulus(205, 400); checkOutput("post_rst_a2", 16'(apple[2]), 16'h1);

        head2_x = 10'd442; head2_y = 10'd410;
        doTick2();
        checkOutput("dual_mask", 16'(eaten_mask2), 16'h0C);
        checkOutput("dual_score", 16'(score2), 16'h2);
        @(negedge clk);
        head2_x = 10'd40; head2_y = 10'd85;
        doTick2();
        checkOutput("sat_mask0", 16'(eaten_mask2), 16'h01);
        checkOutput("sat_score3", 16'(score2), 16'h3);
        @(negedge clk);
        head2_x = 10'd620; head2_y = 10'd60;
        doTick2();
        checkOutput("sat_mask4", 16'(eaten_mask2), 16'h10);
        checkOutput("sat_hold", 16'(score2), 16'h3);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
